// File: rtl/motor_ramp_ctrl.sv
// Speed-command front end for one motor channel: ramps the applied speed toward a signed
// command, parks in a PWM-off dead time across direction reversals, and feeds a PWM generator.
module motor_ramp_ctrl #(
  parameter int unsigned PERIOD      = 1000,
  parameter int unsigned STEP        = 10,
  parameter int unsigned RAMP_DIV    = 4,
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_dir,
  input  logic [7:0]  cmd_speed,
  input  logic        estop,
  output logic        pwm_en,
  output logic [31:0] period,
  output logic [31:0] duty_cycle,
  output logic        dir,
  output logic [7:0]  speed,
  output logic        at_target
);

  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [8:0]    STEP_W    = 9'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t          state;
  logic            tgt_dir;
  logic [7:0]      tgt_mag;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   dead_cnt;

  logic [7:0]      goal_c;
  logic [8:0]      diff_c;
  logic [7:0]      stepped_c;
  logic [31:0]     duty_c;

  // Goal is zero while a reversal is pending; one ramp step never overshoots the goal.
  always_comb begin
    goal_c    = (tgt_dir == dir) ? tgt_mag : 8'd0;
    diff_c    = (goal_c >= speed) ? (9'(goal_c) - 9'(speed)) : (9'(speed) - 9'(goal_c));
    stepped_c = goal_c;
    if (diff_c > STEP_W) begin
      if (goal_c > speed) stepped_c = 8'(9'(speed) + STEP_W);
      else                stepped_c = 8'(9'(speed) - STEP_W);
    end
    duty_c    = 32'((40'(speed) * 40'(PERIOD)) >> 8);
  end

  // Command targets; estop clears the magnitude and masks commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_dir <= 1'b0;
      tgt_mag <= 8'd0;
    end else if (estop) begin
      tgt_mag <= 8'd0;
    end else if (cmd_valid) begin
      tgt_dir <= cmd_dir;
      tgt_mag <= cmd_speed;
    end
  end

  // Ramp / dead-time state machine with registered pwm_en, speed and dir.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pwm_en   <= 1'b0;
      speed    <= 8'd0;
      dir      <= 1'b0;
      presc    <= '0;
      dead_cnt <= '0;
    end else if (estop) begin
      state    <= IDLE;
      pwm_en   <= 1'b0;
      speed    <= 8'd0;
      presc    <= '0;
      dead_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          presc    <= '0;
          dead_cnt <= '0;
          if (tgt_mag != 8'd0) begin
            if (tgt_dir == dir) begin
              state  <= RUN;
              pwm_en <= 1'b1;
            end else begin
              state  <= DEAD;
            end
          end
        end
        RUN: begin
          if ((speed == 8'd0) && (goal_c == 8'd0)) begin
            state  <= IDLE;
            pwm_en <= 1'b0;
            presc  <= '0;
          end else if (presc == PRE_LAST) begin
            presc  <= '0;
            speed  <= stepped_c;
          end else begin
            presc  <= presc + PW'(1);
          end
        end
        DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            dead_cnt <= '0;
            dir      <= tgt_dir;
            if (tgt_mag != 8'd0) begin
              state  <= RUN;
              pwm_en <= 1'b1;
            end else begin
              state  <= IDLE;
            end
          end else begin
            dead_cnt <= dead_cnt + DW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          pwm_en <= 1'b0;
        end
      endcase
    end
  end

  // Duty follows speed one cycle later, but estop zeroes it on the same edge as speed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     duty_cycle <= 32'd0;
    else if (estop) duty_cycle <= 32'd0;
    else            duty_cycle <= duty_c;
  end

  assign period    = 32'(PERIOD);
  assign at_target = ((state == RUN) && (dir == tgt_dir) && (speed == tgt_mag)) ||
                     ((state == IDLE) && (tgt_mag == 8'd0));

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed scenarios and random commands checked cycle by cycle
// against an expected-timeline model built from ramp, dead-time and reversal rules.
module tb_motor_ramp_ctrl;

  localparam int unsigned PERIOD      = 1000;
  localparam int unsigned STEP        = 10;
  localparam int unsigned RAMP_DIV    = 4;
  localparam int unsigned DEAD_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_dir, estop;
  logic [7:0]  cmd_speed;
  logic        pwm_en, dir, at_target;
  logic [31:0] period, duty_cycle;
  logic [7:0]  speed;

  motor_ramp_ctrl #(
    .PERIOD(PERIOD), .STEP(STEP), .RAMP_DIV(RAMP_DIV), .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_speed(cmd_speed), .estop(estop), .pwm_en(pwm_en), .period(period),
    .duty_cycle(duty_cycle), .dir(dir), .speed(speed), .at_target(at_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-edge observation of the DUT outputs.
  typedef struct {
    bit          pwm;
    bit          dr;
    int unsigned spd;
    int unsigned duty;
    bit          at;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_run;
  bit          m_dir;
  int unsigned m_sp, m_prev, m_t, m_entry;

  function automatic void model_reset();
    m_run  = 1'b0;
    m_dir  = 1'b0;
    m_sp   = 0;
    m_prev = 0;
    exp_q.delete();
  endfunction

  function automatic void push(input bit pwm, input bit d, input int unsigned sp, input bit at);
    exp_t x;
    x.pwm  = pwm;
    x.dr   = d;
    x.spd  = sp;
    x.duty = (m_prev * PERIOD) / 256;
    x.at   = at;
    exp_q.push_back(x);
    m_prev = sp;
    m_t++;
  endfunction

  // Speed moves toward goal only on edges that are a whole number of ramp periods after RUN entry.
  function automatic void ramp_to(input int unsigned goal, input bit d, input int unsigned m);
    int unsigned t;
    while (m_sp != goal) begin
      t = m_t + 1;
      if (((t - m_entry) % RAMP_DIV) == 0) begin
        if (goal > m_sp) m_sp = (goal - m_sp > STEP) ? m_sp + STEP : goal;
        else             m_sp = (m_sp - goal > STEP) ? m_sp - STEP : goal;
      end
      push(1'b1, m_dir, m_sp, (m_dir == d) && (m_sp == m));
    end
  endfunction

  function automatic void settle(input bit d, input int unsigned m);
    repeat (RAMP_DIV + 2) push(1'b1, m_dir, m_sp, (m_dir == d) && (m_sp == m));
  endfunction

  // Builds the full expected timeline for a command loaded at the next edge.
  function automatic void plan(input bit d, input int unsigned m);
    int unsigned goal;
    push(m_run, m_dir, m_sp, m_run ? ((m_dir == d) && (m_sp == m)) : (m == 0));
    if (m_run) begin
      goal = (d == m_dir) ? m : 0;
      ramp_to(goal, d, m);
      if (goal != 0) begin
        settle(d, m);
        return;
      end
      m_run = 1'b0;
      push(1'b0, m_dir, 0, m == 0);
    end
    if (m == 0) begin
      repeat (3) push(1'b0, m_dir, 0, 1'b1);
      return;
    end
    if (d != m_dir) begin
      repeat (DEAD_CYCLES) push(1'b0, m_dir, 0, 1'b0);
      m_dir = d;
    end
    m_run   = 1'b1;
    m_entry = m_t + 1;
    m_sp    = 0;
    push(1'b1, m_dir, 0, 1'b0);
    ramp_to(m, d, m);
    settle(d, m);
  endfunction

  task automatic issue(input bit d, input logic [7:0] m);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_speed = m;
    plan(d, int'(m));
  endtask

  task automatic drain(input int n);
    exp_t x;
    int   k = 0;
    while ((exp_q.size() > 0) && ((n < 0) || (k < n))) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      x = exp_q.pop_front();
      check("pwm_en",     32'(pwm_en),    32'(x.pwm));
      check("dir",        32'(dir),       32'(x.dr));
      check("speed",      32'(speed),     x.spd);
      check("duty_cycle", duty_cycle,     x.duty);
      check("at_target",  32'(at_target), 32'(x.at));
      k++;
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_speed"},  32'(speed),     32'd0);
    check({tag, "_pwm"},    32'(pwm_en),    32'd0);
    check({tag, "_duty"},   duty_cycle,     32'd0);
    check({tag, "_dir"},    32'(dir),       32'd0);
    check({tag, "_at"},     32'(at_target), 32'd1);
    check({tag, "_period"}, period,         32'(PERIOD));
  endtask

  task automatic async_reset_pulse(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle({tag, "_now"});
    @(negedge clk);
    chk_idle({tag, "_held"});
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      chk_idle({tag, "_after"});
    end
  endtask

  // A direction change must land on an edge where the PWM was already off.
  bit last_dir = 1'b0;
  bit last_pwm = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dir !== last_dir) check("dir_change_pwm_off", 32'(last_pwm), 32'd0);
    last_dir = dir;
    last_pwm = pwm_en;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          d;
    logic [7:0]  m;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_speed = 8'd0; estop = 1'b0;
    m_t = 0; m_entry = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("post_reset");

    issue(1'b0, 8'd100); drain(-1);
    check("ramp100_speed", 32'(speed), 32'd100);
    check("ramp100_duty",  duty_cycle, 32'd390);
    check("ramp100_at",    32'(at_target), 32'd1);

    issue(1'b0, 8'd0);  drain(-1);
    issue(1'b0, 8'd25); drain(-1);
    check("ramp25_speed", 32'(speed), 32'd25);
    check("ramp25_duty",  duty_cycle, 32'd97);

    issue(1'b0, 8'd30); drain(-1);
    issue(1'b1, 8'd20); drain(-1);
    check("rev_dir",   32'(dir),   32'd1);
    check("rev_speed", 32'(speed), 32'd20);

    issue(1'b0, 8'd50); drain(-1);
    issue(1'b0, 8'd0);  drain(-1);
    check("stop_pwm", 32'(pwm_en),    32'd0);
    check("stop_at",  32'(at_target), 32'd1);
    check("stop_dir", 32'(dir),       32'd0);

    // estop mid-ramp together with a command that must be ignored
    issue(1'b0, 8'd200); drain(18);
    check("estop_pre_speed", 32'(speed), 32'd40);
    estop = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_speed = 8'd200;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk_idle("estop");
    end
    estop = 1'b0; cmd_valid = 1'b0;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      chk_idle("estop_after");
    end

    issue(1'b1, 8'd60);  drain(4);
    async_reset_pulse("arst_dead");
    issue(1'b0, 8'd150); drain(10);
    async_reset_pulse("arst_ramp");

    for (int i = 0; i < 25; i++) begin
      d = 1'($urandom_range(0, 1));
      m = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      issue(d, m);
      drain(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
